calc_sequencer: RTL and testbench

//  Central controller for the 4-digit calculator: accepts decoded keypad codes and builds two decimal operands.
//  On '=' it runs the sequence: adder start/done, then binary-to-BCD conversion start/done (listo).
//  It then latches the BCD result for the 7-segment driver.

---
 rtl/calc_pkg.sv | 14 +
 rtl/calc_key_accum.sv | 40 ++++
 rtl/calc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared state type, key codes, width defaults and decimal shift helper
package calc_pkg;
    localparam int OP_W_DEF        = 12;
    localparam int RES_W_DEF       = 16;
    localparam int MAX_DIGITS_DEF  = 3;
    localparam int TIMEOUT_CYC_DEF = 1023;
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_EQ  = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    typedef enum logic [2:0] {ENTER_A, ENTER_B, ADD_WAIT, CONV_WAIT, SHOW} state_t;
    function automatic logic [31:0] mul10_add(input logic [31:0] op, input logic [3:0] d);
        return (op << 3) + (op << 1) + {28'd0, d};
    endfunction
endpackage

// File: rtl/calc_key_accum.sv
// calc_key_accum: one operand being typed - binary value, BCD shadow and digit count
module calc_key_accum
    import calc_pkg::*;
#(
    parameter int OP_W       = OP_W_DEF,
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic [OP_W-1:0] load_value,
    input  logic            digit_en,
    input  logic [3:0]      digit,
    output logic [OP_W-1:0] value,
    output logic [15:0]     bcd,
    output logic [CW-1:0]   count
);
    // clear with a digit restarts the operand at that digit; digits past MAX_DIGITS are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
            bcd   <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            bcd   <= '0;
            count <= '0;
        end else if (clear) begin
            value <= digit_en ? OP_W'(digit) : '0;
            bcd   <= digit_en ? {12'd0, digit} : '0;
            count <= digit_en ? CW'(1) : '0;
        end else if (digit_en && count < CW'(MAX_DIGITS)) begin
            value <= OP_W'(mul10_add(32'(value), digit));
            bcd   <= {bcd[11:0], digit};
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven operand entry and add -> BCD-convert -> display sequencing
// Optional ENTRY_ECHO_EN: while typing, the display echoes the operand being entered.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int OP_W        = OP_W_DEF,
    parameter int RES_W       = RES_W_DEF,
    parameter int MAX_DIGITS  = MAX_DIGITS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [OP_W-1:0]  num1,
    output logic [OP_W-1:0]  num2,
    output logic             add_start,
    input  logic             add_done,
    input  logic [RES_W-1:0] sum_in,
    output logic             conv_start,
    output logic [RES_W-1:0] conv_value,
    input  logic             conv_done,
    input  logic [15:0]      bcd_in,
    output logic [15:0]      disp_bcd,
    output logic             disp_valid,
    output logic             busy,
    output logic             err
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    state_t          state, state_n;
    logic            live, acc, is_dig, t_out;
    logic            a_clr, b_clr, a_dig, b_dig, a_load, go_conv, go_show, tmo, clr_all;
    logic [WW-1:0]   wcnt;
    logic [15:0]     a_bcd, b_bcd, bcd_r;
    logic [CW-1:0]   a_cnt, b_cnt;
    logic            dv_r;
    logic [OP_W-1:0] chain_val;

    assign busy      = state == ADD_WAIT || state == CONV_WAIT;
    assign key_ready = live && !busy;
    assign acc       = key_valid && key_ready;
    assign is_dig    = key_code < 4'd10;
    assign t_out     = wcnt == WW'(TIMEOUT_CYC - 1);
    assign chain_val = |conv_value[RES_W-1:OP_W] ? '1 : conv_value[OP_W-1:0];

    calc_key_accum #(.OP_W(OP_W), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk(clk), .rst(rst), .clear(a_clr), .load(a_load), .load_value(chain_val),
        .digit_en(a_dig), .digit(key_code), .value(num1), .bcd(a_bcd), .count(a_cnt)
    );

    calc_key_accum #(.OP_W(OP_W), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk(clk), .rst(rst), .clear(b_clr), .load(1'b0), .load_value('0),
        .digit_en(b_dig), .digit(key_code), .value(num2), .bcd(b_bcd), .count(b_cnt)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ENTER_A;
        else      state <= state_n;
    end

    // next state and per-cycle operand/sequence controls; clear overrides everything
    always_comb begin
        state_n = state;
        a_clr   = 1'b0;
        b_clr   = 1'b0;
        a_dig   = 1'b0;
        b_dig   = 1'b0;
        a_load  = 1'b0;
        go_conv = 1'b0;
        go_show = 1'b0;
        tmo     = 1'b0;
        clr_all = 1'b0;
        case (state)
            ENTER_A: if (acc) begin
                if (is_dig) a_dig = 1'b1;
                else if (key_code == KEY_ADD) begin
                    b_clr   = 1'b1;
                    state_n = ENTER_B;
                end else if (key_code == KEY_EQ) begin
                    b_clr   = 1'b1;
                    state_n = ADD_WAIT;
                end
            end
            ENTER_B: if (acc) begin
                if (is_dig) b_dig = 1'b1;
                else if (key_code == KEY_EQ) state_n = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (add_done) begin
                    go_conv = 1'b1;
                    state_n = CONV_WAIT;
                end else if (t_out) begin
                    tmo     = 1'b1;
                    state_n = SHOW;
                end
            end
            CONV_WAIT: begin
                if (conv_done) begin
                    go_show = 1'b1;
                    state_n = SHOW;
                end else if (t_out) begin
                    tmo     = 1'b1;
                    state_n = SHOW;
                end
            end
            SHOW: if (acc) begin
                if (is_dig) begin
                    a_clr   = 1'b1;
                    b_clr   = 1'b1;
                    a_dig   = 1'b1;
                    state_n = ENTER_A;
                end else if (key_code == KEY_ADD) begin
                    a_load  = 1'b1;
                    b_clr   = 1'b1;
                    state_n = ENTER_B;
                end
            end
            default: state_n = ENTER_A;
        endcase
        if (acc && key_code == KEY_CLR) begin
            clr_all = 1'b1;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            state_n = ENTER_A;
        end
    end

    // start pulses, conversion operand, wait timer, error flag and latched result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live       <= 1'b0;
            add_start  <= 1'b0;
            conv_start <= 1'b0;
            conv_value <= '0;
            wcnt       <= '0;
            err        <= 1'b0;
            bcd_r      <= '0;
            dv_r       <= 1'b0;
        end else begin
            live       <= 1'b1;
            add_start  <= state != ADD_WAIT && state_n == ADD_WAIT;
            conv_start <= go_conv;
            if (go_conv) conv_value <= sum_in;
            wcnt       <= (busy && state_n == state) ? wcnt + WW'(1) : '0;
            err        <= clr_all ? 1'b0 : (err | tmo);
            if (clr_all) begin
                bcd_r <= '0;
                dv_r  <= 1'b0;
            end else if (go_show) begin
                bcd_r <= bcd_in;
                dv_r  <= 1'b1;
            end else if (tmo) dv_r <= 1'b0;
        end
    end

`ifdef ENTRY_ECHO_EN
    assign disp_bcd   = state == ENTER_A ? a_bcd : state == ENTER_B ? b_bcd : bcd_r;
    assign disp_valid = state == ENTER_A ? a_cnt != '0 : state == ENTER_B ? b_cnt != '0 : dv_r;
`else
    logic unused_shadow;
    assign unused_shadow = ^{a_bcd, b_bcd, a_cnt, b_cnt};
    assign disp_bcd   = bcd_r;
    assign disp_valid = dv_r;
`endif
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench with bench-side adder and BCD converter models
module tb_calc_sequencer;
    localparam int TMO = 1023;
    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_EQ  = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        add_done = 1'b0;
    logic [15:0] sum_in = 16'd0;
    logic        conv_done = 1'b0;
    logic [15:0] bcd_in = 16'd0;
    logic        key_ready, add_start, conv_start, disp_valid, busy, err;
    logic [11:0] num1, num2;
    logic [15:0] conv_value, disp_bcd;

    typedef struct packed {
        logic [11:0] n1;
        logic [11:0] n2;
    } op_t;

    op_t         op_q[$];
    logic [15:0] res_q[$];
    int          n_tests = 0, n_fail = 0, n_add = 0, n_eq = 0;
    int          add_cd = -1, conv_cd = -1, add_lat = 2, conv_lat = 2;
    bit          add_en = 1'b1, conv_en = 1'b1, disp_chk = 1'b0, kick_conv = 1'b0, conv_seen = 1'b0;
    logic [15:0] pend_sum = 16'd0, pend_bcd = 16'd0;

    calc_sequencer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .num1(num1), .num2(num2), .add_start(add_start), .add_done(add_done), .sum_in(sum_in),
        .conv_start(conv_start), .conv_value(conv_value), .conv_done(conv_done), .bcd_in(bcd_in),
        .disp_bcd(disp_bcd), .disp_valid(disp_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // one clock: sample outputs at negedge, score them, then drive the adder/converter models
    task automatic tick();
        op_t         o;
        logic [15:0] e;
        @(negedge clk);
        add_done  = 1'b0;
        conv_done = 1'b0;
        if (disp_chk) begin
            disp_chk = 1'b0;
            if (res_q.size() == 0) check("res_q_underflow", 1, 0);
            else begin
                e = res_q.pop_front();
                check("disp_valid", 32'(disp_valid), 1);
                check("disp_bcd", 32'(disp_bcd), 32'(e));
            end
        end
        if (add_start) begin
            n_add++;
            if (op_q.size() == 0) check("spurious_add_start", 1, 0);
            else begin
                o = op_q.pop_front();
                check("num1_at_start", 32'(num1), 32'(o.n1));
                check("num2_at_start", 32'(num2), 32'(o.n2));
                pend_sum = 16'(o.n1) + 16'(o.n2);
            end
            if (add_en) add_cd = add_lat;
        end
        if (conv_start) begin
            conv_seen = 1'b1;
            check("conv_value", 32'(conv_value), 32'(pend_sum));
            pend_bcd = to_bcd(int'(pend_sum));
            if (conv_en) conv_cd = conv_lat;
        end
        if (add_cd == 0) begin
            add_done = 1'b1;
            sum_in   = pend_sum;
        end
        if (add_cd >= 0) add_cd--;
        if (conv_cd == 0) begin
            conv_done = 1'b1;
            bcd_in    = pend_bcd;
            disp_chk  = 1'b1;
        end
        if (conv_cd >= 0) conv_cd--;
        if (kick_conv) begin
            kick_conv = 1'b0;
            conv_done = 1'b1;
            bcd_in    = 16'h1234;
        end
    endtask

    task automatic wait_ready();
        int i = 0;
        while (!key_ready && i < 200) begin
            tick();
            i++;
        end
        if (!key_ready) check("key_ready_timeout", 32'(key_ready), 1);
    endtask

    task automatic press(input logic [3:0] k);
        wait_ready();
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_eq(input logic [11:0] n1, input logic [11:0] n2, input logic [15:0] r, input bit has_res);
        op_q.push_back({n1, n2});
        if (has_res) res_q.push_back(r);
        n_eq++;
        press(K_EQ);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        #1 rst = 1'b0;
        tick();
        tick();
        check("rst_key_ready", 32'(key_ready), 0);
        check("rst_add_start", 32'(add_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_num1", 32'(num1), 0);
        rst = 1'b1;
        tick();
        check("ready_after_rst", 32'(key_ready), 1);

        press(4'd1); press(4'd2); press(4'd3);
        check("num1_123", 32'(num1), 123);
        press(K_ADD);
        press(4'd4); press(4'd5); press(4'd6);
        check("num2_456", 32'(num2), 456);
        press_eq(12'd123, 12'd456, 16'h0579, 1'b1);
        wait_ready();

        press(K_ADD);
        check("chain_num1", 32'(num1), 579);
        check("chain_num2", 32'(num2), 0);
        press(4'd1);
        press_eq(12'd579, 12'd1, 16'h0580, 1'b1);
        wait_ready();

        press(K_CLR);
        check("clr_num1", 32'(num1), 0);
        check("clr_disp_valid", 32'(disp_valid), 0);
        repeat (4) press(4'd9);
        check("max_digits", 32'(num1), 999);
        press(4'hD);
        check("ignored_key", 32'(num1), 999);
        press(K_ADD);
        repeat (3) press(4'd9);
        press_eq(12'd999, 12'd999, 16'h1998, 1'b1);
        wait_ready();

        press(4'd8);
        check("show_digit_num1", 32'(num1), 8);
        check("show_digit_num2", 32'(num2), 0);
`ifdef ENTRY_ECHO_EN
        check("show_digit_disp", 32'(disp_bcd), 32'h0008);
`else
        check("show_digit_disp", 32'(disp_bcd), 32'h1998);
`endif

        press(K_CLR); press(4'd1); press(K_ADD); press(4'd2);
        add_lat = 6;
        press_eq(12'd1, 12'd2, 16'h0003, 1'b1);
        key_valid = 1'b1;
        key_code  = 4'd5;
        repeat (3) begin
            tick();
            check("busy_key_ready", 32'(key_ready), 0);
            check("busy_flag", 32'(busy), 1);
            check("busy_num1", 32'(num1), 1);
            check("busy_num2", 32'(num2), 2);
        end
        key_valid = 1'b0;
        wait_ready();
        add_lat = 2;

        press(K_CLR); press(4'd7);
        add_en = 1'b0;
        press_eq(12'd7, 12'd0, 16'h0000, 1'b0);
        cnt = 0;
        while (!err && cnt < TMO + 50) begin
            tick();
            cnt++;
        end
        check("timeout_cycles", 32'(cnt), TMO);
        check("timeout_err", 32'(err), 1);
        check("timeout_disp_valid", 32'(disp_valid), 0);
        check("timeout_show_ready", 32'(key_ready), 1);
        add_en = 1'b1;
        press(K_EQ);
        tick();
        check("show_eq_ignored", 32'(busy), 0);
        press(K_CLR);
        check("clr_err", 32'(err), 0);

        press(4'd1); press(K_ADD); press(4'd1);
        conv_en   = 1'b0;
        conv_seen = 1'b0;
        press_eq(12'd1, 12'd1, 16'h0000, 1'b0);
        cnt = 0;
        while (!conv_seen && cnt < 50) begin
            tick();
            cnt++;
        end
        check("conv_start_seen", 32'(conv_seen), 1);
        tick();
        check("conv_wait_busy", 32'(busy), 1);
        rst = 1'b0;
        tick();
        check("midrst_key_ready", 32'(key_ready), 0);
        check("midrst_nums", 32'({num1, num2}), 0);
        check("midrst_starts", 32'({add_start, conv_start}), 0);
        check("midrst_conv_value", 32'(conv_value), 0);
        check("midrst_disp", 32'({disp_valid, disp_bcd}), 0);
        check("midrst_busy_err", 32'({busy, err}), 0);
        rst = 1'b1;
        kick_conv = 1'b1;
        tick();
        tick();
        check("late_conv_disp_valid", 32'(disp_valid), 0);
        check("late_conv_disp_bcd", 32'(disp_bcd), 0);
        check("late_conv_busy", 32'(busy), 0);
        check("late_conv_ready", 32'(key_ready), 1);
        conv_en = 1'b1;

        press(K_CLR); press(4'd4); press(4'd2);
        check("entry_num1", 32'(num1), 42);
`ifdef ENTRY_ECHO_EN
        check("echo_disp_bcd", 32'(disp_bcd), 32'h0042);
        check("echo_disp_valid", 32'(disp_valid), 1);
`else
        check("noecho_disp_bcd", 32'(disp_bcd), 0);
        check("noecho_disp_valid", 32'(disp_valid), 0);
`endif

        tick();
        check("op_q_left", 32'(op_q.size()), 0);
        check("res_q_left", 32'(res_q.size()), 0);
        check("add_start_count", 32'(n_add), 32'(n_eq));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
